// File: rtl/wb_serial_bridge.sv
// Wishbone slave to byte-stream bridge: each access becomes an op/addr/count[/data]
// frame on axis_o; reads complete on the first byte returned on axis_i or on timeout.
module wb_serial_bridge #(
  parameter int BYTES          = 1,
  parameter int ADDR_BITS      = 8,
  parameter int SEL_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [ADDR_BITS-1:0] s_wb_addr,
  input  logic [BYTES*8-1:0]   s_wb_dat_m2s,
  output logic [BYTES*8-1:0]   s_wb_dat_s2m,
  input  logic                 s_wb_we,
  input  logic [SEL_WIDTH-1:0] s_wb_sel,
  input  logic                 s_wb_stb,
  input  logic                 s_wb_cyc,
  output logic                 s_wb_ack,
  output logic                 s_wb_stall,
  output logic                 s_wb_err,
  input  logic                 axis_o_tready,
  output logic                 axis_o_tvalid,
  output logic                 axis_o_tlast,
  output logic [BYTES*8-1:0]   axis_o_tdata,
  output logic                 axis_i_tready,
  input  logic                 axis_i_tvalid,
  input  logic                 axis_i_tlast,
  input  logic [BYTES*8-1:0]   axis_i_tdata
);

  localparam int DW = BYTES * 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DW-1:0] COUNT_ONE = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_ADDR,
    SEND_COUNT,
    SEND_DATA,
    WAIT_RESP,
    ACK,
    ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DW-1:0]          data_q;
  logic                   we_q;
  logic                   lost_q;
  logic [TW-1:0]          timer_q;
  logic [DW-1:0]          rdata_q;
  logic                   accept;
  logic                   timeout_hit;

  logic unused_ok;
  assign unused_ok = ^{s_wb_sel, axis_i_tlast};

  assign accept      = (state_q == IDLE) && s_wb_cyc && s_wb_stb;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMAX);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept)        state_d = SEND_OP;
      SEND_OP:    if (axis_o_tready) state_d = SEND_ADDR;
      SEND_ADDR:  if (axis_o_tready) state_d = SEND_COUNT;
      SEND_COUNT: if (axis_o_tready) state_d = we_q ? SEND_DATA : WAIT_RESP;
      SEND_DATA:  if (axis_o_tready) state_d = ACK;
      // A response arriving on the timeout cycle takes priority over the error.
      WAIT_RESP: begin
        if (axis_i_tvalid)    state_d = ACK;
        else if (timeout_hit) state_d = ERR;
      end
      ACK:        state_d = IDLE;
      ERR:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // lost_q remembers a dropped cyc so a re-raised cyc cannot collect a stale ack.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      lost_q  <= 1'b0;
      timer_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= s_wb_addr;
        data_q <= s_wb_dat_m2s;
        we_q   <= s_wb_we;
        lost_q <= 1'b0;
      end else if ((state_q != IDLE) && !s_wb_cyc) begin
        lost_q <= 1'b1;
      end

      if (state_q == WAIT_RESP) begin
        timer_q <= timer_q + TW'(1);
      end else begin
        timer_q <= '0;
      end

      if ((state_q == WAIT_RESP) && axis_i_tvalid) begin
        rdata_q <= axis_i_tdata;
      end
    end
  end

  always_comb begin
    s_wb_stall    = 1'b1;
    s_wb_ack      = 1'b0;
    s_wb_err      = 1'b0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    case (state_q)
      IDLE: s_wb_stall = 1'b0;
      SEND_OP: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = DW'(we_q);
      end
      SEND_ADDR: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = DW'(addr_q);
      end
      SEND_COUNT: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = COUNT_ONE;
        axis_o_tlast  = !we_q;
      end
      SEND_DATA: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = data_q;
        axis_o_tlast  = 1'b1;
      end
      ACK:     s_wb_ack = s_wb_cyc && !lost_q;
      ERR:     s_wb_err = s_wb_cyc && !lost_q;
      default: ;
    endcase
  end

  assign axis_i_tready = 1'b1;
  assign s_wb_dat_s2m  = rdata_q;

endmodule

// File: tb/tb_wb_serial_bridge.sv
// Randomized bench for wb_serial_bridge against a frame-level reference model.
module tb_wb_serial_bridge;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [7:0] s_wb_addr = '0;
  logic [7:0] s_wb_dat_m2s = '0;
  logic [7:0] s_wb_dat_s2m;
  logic       s_wb_we = 1'b0;
  logic [0:0] s_wb_sel = 1'b1;
  logic       s_wb_stb = 1'b0;
  logic       s_wb_cyc = 1'b0;
  logic       s_wb_ack, s_wb_stall, s_wb_err;
  logic       axis_o_tready = 1'b1;
  logic       axis_o_tvalid, axis_o_tlast;
  logic [7:0] axis_o_tdata;
  logic       axis_i_tready;
  logic       axis_i_tvalid = 1'b0;
  logic       axis_i_tlast = 1'b1;
  logic [7:0] axis_i_tdata = '0;

  always #5 clk = ~clk;

  wb_serial_bridge #(
    .BYTES(1), .ADDR_BITS(8), .SEL_WIDTH(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .areset(areset),
    .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_dat_s2m(s_wb_dat_s2m),
    .s_wb_we(s_wb_we), .s_wb_sel(s_wb_sel), .s_wb_stb(s_wb_stb), .s_wb_cyc(s_wb_cyc),
    .s_wb_ack(s_wb_ack), .s_wb_stall(s_wb_stall), .s_wb_err(s_wb_err),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // stimulus configuration read by the model
  bit         rand_tr = 1'b0;
  int         exp_delay = 0;
  logic [7:0] resp_byte = '0;

  // model state (owned by the compare process)
  logic [7:0] exp_q[$];
  bit         exp_we = 1'b0;
  bit         model_busy = 1'b0;
  bit         suppressed = 1'b0;
  bit         done_is_ack = 1'b0;
  int         done_cycle = -1;
  logic [7:0] pending_rdata = '0;
  logic [7:0] model_rdata = '0;
  int         bytes_seen = 0;
  bit         last_seen = 1'b0;
  int         frames_done = 0;
  logic [7:0] log_data[$];
  bit         log_last[$];
  int         ack_cnt = 0, err_cnt = 0;
  int         accept_cycle = 0, ack_cycle = 0, err_cycle = 0, wait_entry = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      axis_o_tready = rand_tr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    bit done_now;
    bit exp_tv;
    if (areset) begin
      check("rst_stall", s_wb_stall, 0);
      check("rst_ack", s_wb_ack, 0);
      check("rst_err", s_wb_err, 0);
      check("rst_tvalid", axis_o_tvalid, 0);
      check("rst_tlast", axis_o_tlast, 0);
      check("rst_tdata", axis_o_tdata, 0);
      check("rst_dat_s2m", s_wb_dat_s2m, 0);
      check("rst_i_tready", axis_i_tready, 1);
      exp_q.delete();
      model_busy  = 1'b0;
      suppressed  = 1'b0;
      done_cycle  = -1;
      model_rdata = '0;
    end else begin
      done_now = model_busy && (done_cycle == cyc_n);
      if (done_now && done_is_ack && !exp_we) model_rdata = pending_rdata;
      exp_tv = model_busy && (exp_q.size() > 0);

      check("stall", s_wb_stall, model_busy);
      check("tvalid", axis_o_tvalid, exp_tv);
      if (exp_tv) begin
        check("tdata", axis_o_tdata, exp_q[0]);
        check("tlast", axis_o_tlast, exp_q.size() == 1);
      end
      check("ack", s_wb_ack, done_now && done_is_ack && s_wb_cyc && !suppressed);
      check("err", s_wb_err, done_now && !done_is_ack && s_wb_cyc && !suppressed);
      check("dat_s2m", s_wb_dat_s2m, model_rdata);
      check("i_tready", axis_i_tready, 1);

      if (s_wb_ack) begin ack_cnt++; ack_cycle = cyc_n; end
      if (s_wb_err) begin err_cnt++; err_cycle = cyc_n; end

      if (exp_tv && axis_o_tready) begin
        log_data.push_back(exp_q[0]);
        log_last.push_back(exp_q.size() == 1);
        void'(exp_q.pop_front());
        bytes_seen++;
        if (exp_q.size() == 0) begin
          last_seen = 1'b1;
          if (exp_we) begin
            done_cycle  = cyc_n + 1;
            done_is_ack = 1'b1;
          end else begin
            wait_entry = cyc_n + 1;
            if (exp_delay <= TO - 1) begin
              done_cycle    = cyc_n + 2 + exp_delay;
              done_is_ack   = 1'b1;
              pending_rdata = resp_byte;
            end else begin
              done_cycle  = cyc_n + 1 + TO;
              done_is_ack = 1'b0;
            end
          end
        end
      end

      if (model_busy && !s_wb_cyc) suppressed = 1'b1;

      if (done_now) begin
        model_busy = 1'b0;
        frames_done++;
      end else if (!model_busy && s_wb_cyc && s_wb_stb) begin
        exp_q.delete();
        exp_q.push_back({7'b0, s_wb_we});
        exp_q.push_back(s_wb_addr);
        exp_q.push_back(8'h01);
        if (s_wb_we) exp_q.push_back(s_wb_dat_m2s);
        exp_we       = s_wb_we;
        suppressed   = 1'b0;
        bytes_seen   = 0;
        last_seen    = 1'b0;
        done_cycle   = -1;
        accept_cycle = cyc_n;
        model_busy   = 1'b1;
      end
    end
  end

  task automatic access(input bit we, input logic [7:0] addr, input logic [7:0] data,
                        input int d, input logic [7:0] resp, input bit drop);
    int n;
    int fd0;
    exp_delay = d;
    resp_byte = resp;
    fd0 = frames_done;
    @(posedge clk); #1;
    s_wb_addr = addr; s_wb_dat_m2s = data; s_wb_we = we;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1;
    @(posedge clk); #1;
    s_wb_stb = 1'b0;
    if (drop) begin
      n = 0;
      while (bytes_seen < 2 && n < 200) begin @(posedge clk); #1; n++; end
      s_wb_cyc = 1'b0;
    end
    if (!we) begin
      n = 0;
      while (!last_seen && n < 200) begin @(posedge clk); #1; n++; end
      repeat (d) begin @(posedge clk); #1; end
      axis_i_tvalid = 1'b1; axis_i_tdata = resp;
      @(posedge clk); #1;
      axis_i_tvalid = 1'b0;
    end
    n = 0;
    while (frames_done == fd0 && n < 300) begin @(posedge clk); #1; n++; end
    check("frame_completes", frames_done != fd0, 1);
    s_wb_cyc = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, a0, e0;
    #1 areset = 1'b1;
    #1;
    check("async_rst_stall", s_wb_stall, 0);
    check("async_rst_tvalid", axis_o_tvalid, 0);
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    repeat (2) @(posedge clk);

    // write 0x12 <- 0xA5
    b = log_data.size(); a0 = ack_cnt;
    access(1'b1, 8'h12, 8'hA5, 0, 8'h00, 1'b0);
    check("wr_nbytes", log_data.size() - b, 4);
    check("wr_b0", log_data[b], 8'h01);
    check("wr_b1", log_data[b+1], 8'h12);
    check("wr_b2", log_data[b+2], 8'h01);
    check("wr_b3", log_data[b+3], 8'hA5);
    check("wr_tlast", {log_last[b], log_last[b+1], log_last[b+2], log_last[b+3]}, 4'b0001);
    check("wr_acks", ack_cnt - a0, 1);
    check("wr_latency", ack_cycle - accept_cycle, 5);

    // read 0x34, response 0x5C three cycles after the count byte
    b = log_data.size(); a0 = ack_cnt;
    access(1'b0, 8'h34, 8'h00, 2, 8'h5C, 1'b0);
    check("rd_nbytes", log_data.size() - b, 3);
    check("rd_b0", log_data[b], 8'h00);
    check("rd_b1", log_data[b+1], 8'h34);
    check("rd_b2", log_data[b+2], 8'h01);
    check("rd_tlast", {log_last[b], log_last[b+1], log_last[b+2]}, 3'b001);
    check("rd_acks", ack_cnt - a0, 1);
    check("rd_ack_delay", ack_cycle - wait_entry, 3);
    check("rd_data", s_wb_dat_s2m, 8'h5C);

    // write with random backpressure
    rand_tr = 1'b1;
    b = log_data.size(); a0 = ack_cnt;
    access(1'b1, 8'h56, 8'h3C, 0, 8'h00, 1'b0);
    rand_tr = 1'b0;
    check("bp_nbytes", log_data.size() - b, 4);
    check("bp_b1", log_data[b+1], 8'h56);
    check("bp_b3", log_data[b+3], 8'h3C);
    check("bp_acks", ack_cnt - a0, 1);

    // read timeout with late byte
    a0 = ack_cnt; e0 = err_cnt;
    access(1'b0, 8'h40, 8'h00, 20, 8'hEE, 1'b0);
    check("to_errs", err_cnt - e0, 1);
    check("to_acks", ack_cnt - a0, 0);
    check("to_err_delay", err_cycle - wait_entry, 16);
    check("to_data_kept", s_wb_dat_s2m, 8'h5C);

    // response on the timeout cycle wins; one cycle later is an error
    a0 = ack_cnt;
    access(1'b0, 8'h41, 8'h00, TO - 1, 8'h77, 1'b0);
    check("edge_ack", ack_cnt - a0, 1);
    check("edge_data", s_wb_dat_s2m, 8'h77);
    e0 = err_cnt;
    access(1'b0, 8'h42, 8'h00, TO, 8'h88, 1'b0);
    check("edge_err", err_cnt - e0, 1);
    check("edge_data_kept", s_wb_dat_s2m, 8'h77);

    // cyc dropped after the address byte
    b = log_data.size(); a0 = ack_cnt; e0 = err_cnt;
    access(1'b1, 8'h9A, 8'h11, 0, 8'h00, 1'b1);
    check("drop_nbytes", log_data.size() - b, 4);
    check("drop_b3", log_data[b+3], 8'h11);
    check("drop_no_ack", ack_cnt - a0, 0);
    check("drop_no_err", err_cnt - e0, 0);
    a0 = ack_cnt;
    access(1'b0, 8'h9B, 8'h00, 1, 8'h21, 1'b0);
    check("after_drop_ack", ack_cnt - a0, 1);

    // reset during SEND_ADDR
    @(posedge clk); #1;
    s_wb_addr = 8'h77; s_wb_we = 1'b0; s_wb_cyc = 1'b1; s_wb_stb = 1'b1;
    @(posedge clk); #1;
    s_wb_stb = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_addr_byte", axis_o_tdata, 8'h77);
    check("pre_rst_tvalid", axis_o_tvalid, 1);
    #1 areset = 1'b1;
    #1;
    check("mid_rst_tvalid", axis_o_tvalid, 0);
    check("mid_rst_stall", s_wb_stall, 0);
    s_wb_cyc = 1'b0;
    @(posedge clk); #1 areset = 1'b0;
    b = log_data.size(); a0 = ack_cnt;
    access(1'b0, 8'h63, 8'h00, 4, 8'hC3, 1'b0);
    check("post_rst_nbytes", log_data.size() - b, 3);
    check("post_rst_b1", log_data[b+1], 8'h63);
    check("post_rst_ack", ack_cnt - a0, 1);
    check("post_rst_data", s_wb_dat_s2m, 8'hC3);

    // randomized accesses with stray input bytes between them
    for (int i = 0; i < 40; i++) begin
      rand_tr = 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 20)), 8'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        axis_i_tvalid = 1'b1; axis_i_tdata = 8'($urandom);
        @(posedge clk); #1;
        axis_i_tvalid = 1'b0;
      end
    end
    rand_tr = 1'b0;

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
